// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access-size encodings and FSM states.
package load_store_unit_pkg;

   // Funct3 encodings for memory accesses
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_RSP = 2'd2,
      DONE     = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic: store byte enables/replication, load extraction/extension,
// and the access legality check.
module load_store_align
   import load_store_unit_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic        is_read,
   input  logic        is_write,
   input  logic [31:0] store_data,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_offset,
   input  logic [31:0] rdata,
   output logic        illegal,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic [31:0] load_value
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Store path: replicate data across lanes and select byte enables
   always_comb begin
      wstrb = 4'b0000;
      wdata = store_data;
      case (funct3)
         F3_B: begin
            wdata = {4{store_data[7:0]}};
            wstrb = 4'b0001 << offset;
         end
         F3_H: begin
            wdata = {2{store_data[15:0]}};
            wstrb = 4'b0011 << {offset[1], 1'b0};
         end
         F3_W: begin
            wdata = store_data;
            wstrb = 4'b1111;
         end
         default: begin
            wdata = store_data;
            wstrb = 4'b0000;
         end
      endcase
   end

   // Load path: pick the addressed lane and extend according to the captured size
   always_comb begin
      ld_byte = rdata[7:0];
      case (ld_offset)
         2'd0: ld_byte = rdata[7:0];
         2'd1: ld_byte = rdata[15:8];
         2'd2: ld_byte = rdata[23:16];
         2'd3: ld_byte = rdata[31:24];
         default: ld_byte = rdata[7:0];
      endcase
      ld_half = ld_offset[1] ? rdata[31:16] : rdata[15:0];
      case (ld_funct3)
         F3_B:    load_value = {{24{ld_byte[7]}}, ld_byte};
         F3_H:    load_value = {{16{ld_half[15]}}, ld_half};
         F3_W:    load_value = rdata;
         F3_BU:   load_value = {24'h000000, ld_byte};
         F3_HU:   load_value = {16'h0000, ld_half};
         default: load_value = 32'h0000_0000;
      endcase
   end

   // Legality: conflicting request, unsupported size, or misaligned address
   always_comb begin
      illegal = 1'b0;
      if (is_read && is_write) begin
         illegal = 1'b1;
      end else if (is_read) begin
         case (funct3)
            F3_B, F3_BU: illegal = 1'b0;
            F3_H, F3_HU: illegal = offset[0];
            F3_W:        illegal = |offset;
            default:     illegal = 1'b1;
         endcase
      end else if (is_write) begin
         case (funct3)
            F3_B:    illegal = 1'b0;
            F3_H:    illegal = offset[0];
            F3_W:    illegal = |offset;
            default: illegal = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: turns a load/store request into a valid/ready bus transaction, stalls the
// core while it is outstanding, and returns the extended load data.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  Funct3,
   input  logic [31:0] Addr,
   input  logic [31:0] StoreData,
   output logic [31:0] ReadDataMem,
   output logic        Stall,
   output logic        MisalignedFault,
   output logic        BusFault,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   lsu_state_t  state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic        req_valid_q, we_q;
   logic [3:0]  wstrb_q;
   logic [31:0] addr_q, wdata_q, rdm_q, rdm_d;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic        mis_q, mis_d, bus_q, bus_d;

   logic        pending, illegal, launch, timeout_hit;
   logic [3:0]  al_wstrb;
   logic [31:0] al_wdata, load_value;

   load_store_align u_align (
      .funct3     (Funct3),
      .offset     (Addr[1:0]),
      .is_read    (MemRead),
      .is_write   (MemWrite),
      .store_data (StoreData),
      .ld_funct3  (f3_q),
      .ld_offset  (off_q),
      .rdata      (mem_rdata),
      .illegal    (illegal),
      .wstrb      (al_wstrb),
      .wdata      (al_wdata),
      .load_value (load_value)
   );

   assign pending     = MemRead | MemWrite;
   assign launch      = (state_q == IDLE) && pending && !illegal;
   // Last budgeted cycle: counter has already covered TIMEOUT_CYCLES-1 cycles
   assign timeout_hit = (cnt_q >= CntW'(TIMEOUT_CYCLES - 1));

   // Next-state, counter and result/fault logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdm_d   = rdm_q;
      mis_d   = 1'b0;
      bus_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pending) begin
               if (illegal) begin
                  mis_d = 1'b1;
                  rdm_d = 32'h0000_0000;
               end else begin
                  state_d = REQ;
                  cnt_d   = '0;
               end
            end
         end
         REQ: begin
            cnt_d = cnt_q + CntW'(1);
            if (mem_req_ready) begin
               state_d = we_q ? DONE : WAIT_RSP;
            end else if (timeout_hit) begin
               state_d = DONE;
               bus_d   = 1'b1;
               rdm_d   = 32'h0000_0000;
            end
         end
         WAIT_RSP: begin
            cnt_d = cnt_q + CntW'(1);
            // A response on the final budgeted cycle still completes normally
            if (mem_rsp_valid) begin
               state_d = DONE;
               rdm_d   = load_value;
            end else if (timeout_hit) begin
               state_d = DONE;
               bus_d   = 1'b1;
               rdm_d   = 32'h0000_0000;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counter and registered outputs; request fields captured at launch
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         req_valid_q <= 1'b0;
         we_q        <= 1'b0;
         wstrb_q     <= 4'b0000;
         addr_q      <= 32'h0000_0000;
         wdata_q     <= 32'h0000_0000;
         f3_q        <= 3'b000;
         off_q       <= 2'b00;
         rdm_q       <= 32'h0000_0000;
         mis_q       <= 1'b0;
         bus_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_valid_q <= (state_d == REQ);
         rdm_q       <= rdm_d;
         mis_q       <= mis_d;
         bus_q       <= bus_d;
         if (launch) begin
            addr_q  <= {Addr[31:2], 2'b00};
            we_q    <= MemWrite;
            wstrb_q <= MemWrite ? al_wstrb : 4'b0000;
            wdata_q <= MemWrite ? al_wdata : 32'h0000_0000;
            f3_q    <= Funct3;
            off_q   <= Addr[1:0];
         end
      end
   end

   // Stall covers launch cycle plus REQ/WAIT_RSP; never during reset
   always_comb begin
      Stall = !rst && (launch || (state_q == REQ) || (state_q == WAIT_RSP));
   end

   assign ReadDataMem     = rdm_q;
   assign MisalignedFault = mis_q;
   assign BusFault        = bus_q;
   assign mem_req_valid   = req_valid_q;
   assign mem_addr        = addr_q;
   assign mem_we          = we_q;
   assign mem_wstrb       = wstrb_q;
   assign mem_wdata       = wdata_q;

endmodule
